// File: rtl/axis_dac_pacer.sv
// Sample pacer for the MAX5316 DAC path: buffers AXI-Stream DAC codes in a small
// FIFO and releases one per RATE_DIV clocks, holding the last code on underrun.
module axis_dac_pacer #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 4,
    parameter int RATE_DIV    = 1000,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_W-1:0]     m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic [15:0]           underrun_cnt,
    output logic [15:0]           late_cnt,
    output logic                  running
);

    localparam int FW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [FW-1:0] DEPTH_L  = FW'(DEPTH);
    localparam logic [FW-1:0] PRIME_L  = FW'(PRIME_LEVEL);
    localparam logic [15:0]   RELOAD_L = 16'(RATE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                 state_r;
    logic [15:0]            pace_cnt_r;
    logic                   running_r;
    logic [DATA_W-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_r;
    logic [DEPTH_LOG2-1:0]  rd_ptr_r;
    logic [FW-1:0]          fill_r;
    logic                   s_ready_r;
    logic [DATA_W-1:0]      m_data_r;
    logic                   m_valid_r;
    logic [15:0]            underrun_r;
    logic [15:0]            late_r;

    logic                   tick_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   under_s;
    logic                   late_s;
    logic [FW-1:0]          fill_next_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Tick qualification and FIFO occupancy update
    always_comb begin
        tick_s      = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        under_s     = 1'b0;
        late_s      = 1'b0;
        fill_next_s = fill_r;
        tick_s  = (state_r == ST_RUN) && (pace_cnt_r == 16'd0);
        push_s  = s_tvalid && s_ready_r;
        // A pending unaccepted sample blocks the pop; an empty FIFO re-sends the last code
        pop_s   = tick_s && !m_valid_r && (fill_r != {FW{1'b0}});
        under_s = tick_s && !m_valid_r && (fill_r == {FW{1'b0}});
        late_s  = tick_s && m_valid_r;
        case ({push_s, pop_s})
            2'b10:   fill_next_s = fill_r + FW'(1);
            2'b01:   fill_next_s = fill_r - FW'(1);
            default: fill_next_s = fill_r;
        endcase
    end

    // Run-control FSM and pacing down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            running_r  <= 1'b0;
            pace_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    running_r <= 1'b0;
                    if (enable) begin
                        state_r <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                    end else if (fill_r >= PRIME_L) begin
                        state_r    <= ST_RUN;
                        running_r  <= 1'b1;
                        pace_cnt_r <= 16'd0;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end
                    if (pace_cnt_r == 16'd0) begin
                        pace_cnt_r <= RELOAD_L;
                    end else begin
                        pace_cnt_r <= pace_cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents are discarded logically by resetting the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_tdata;
        end
    end

    // FIFO pointers, output register and event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
            fill_r     <= {FW{1'b0}};
            s_ready_r  <= 1'b1;
            m_data_r   <= {DATA_W{1'b0}};
            m_valid_r  <= 1'b0;
            underrun_r <= 16'd0;
            late_r     <= 16'd0;
        end else begin
            fill_r    <= fill_next_s;
            s_ready_r <= (fill_next_s != DEPTH_L);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                m_data_r <= mem_r[rd_ptr_r];
            end
            if (pop_s || under_s) begin
                m_valid_r <= 1'b1;
            end else if (m_valid_r && m_tready) begin
                m_valid_r <= 1'b0;
            end
            if (under_s) begin
                underrun_r <= sat_inc(underrun_r);
            end
            if (late_s) begin
                late_r <= sat_inc(late_r);
            end
        end
    end

    assign s_tready     = s_ready_r;
    assign m_tdata      = m_data_r;
    assign m_tvalid     = m_valid_r;
    assign fill_level   = fill_r;
    assign underrun_cnt = underrun_r;
    assign late_cnt     = late_r;
    assign running      = running_r;

endmodule

// File: tb/tb_axis_dac_pacer.sv
// Directed bench for axis_dac_pacer with RATE_DIV=8, PRIME_LEVEL=2, 16-entry FIFO.
module tb_axis_dac_pacer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  fill_level;
    logic [15:0] underrun_cnt;
    logic [15:0] late_cnt;
    logic        running;

    int checks   = 0;
    int failures = 0;

    logic [15:0] samp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    axis_dac_pacer #(
        .DATA_W(16), .DEPTH_LOG2(4), .RATE_DIV(8), .PRIME_LEVEL(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .fill_level(fill_level), .underrun_cnt(underrun_cnt),
        .late_cnt(late_cnt), .running(running)
    );

    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_v;
        rst = 1'b1; enable = 1'b0; s_tdata = 16'h0; s_tvalid = 1'b0; m_tready = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            enable   = 1'($urandom);
            s_tvalid = 1'($urandom);
            s_tdata  = 16'($urandom);
            m_tready = 1'($urandom);
            tick_clk();
        end
        chk("rst_s_tready", 32'(s_tready), 32'd1);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
        chk("rst_late", 32'(late_cnt), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        rst = 1'b0; enable = 1'b0; s_tvalid = 1'b0; s_tdata = 16'h0; m_tready = 1'b1;

        // Paced stream
        for (int k = 0; k < 4; k++) begin
            s_tvalid = 1'b1; s_tdata = samp[k];
            tick_clk();
        end
        s_tvalid = 1'b0;
        chk("prefill_fill", 32'(fill_level), 32'd4);
        chk("prefill_running", 32'(running), 32'd0);
        enable = 1'b1;
        tick_clk();
        chk("prime_running", 32'(running), 32'd0);
        tick_clk();
        chk("run_running", 32'(running), 32'd1);
        chk("run_no_valid_yet", 32'(m_tvalid), 32'd0);
        for (int i = 0; i < 48; i++) begin
            tick_clk();
            exp_v = ((i % 8) == 0);
            if (i < 32) begin
                chk("pace_valid", 32'(m_tvalid), 32'(exp_v));
                if (exp_v) begin
                    chk("pace_data", 32'(m_tdata), 32'(samp[i / 8]));
                    chk("pace_fill", 32'(fill_level), 32'(3 - i / 8));
                end
            end else if (i < 45) begin
                // Underrun region: last code repeats
                chk("under_valid", 32'(m_tvalid), 32'(exp_v));
                chk("under_data", 32'(m_tdata), 32'h4444);
                chk("under_running", 32'(running), 32'd1);
            end
            if (i == 44) enable = 1'b0;
        end
        chk("under_cnt", 32'(underrun_cnt), 32'd2);
        chk("under_late", 32'(late_cnt), 32'd0);
        chk("disable_running", 32'(running), 32'd0);

        // Full FIFO: 17 back-to-back pushes while disabled
        for (int k = 0; k < 17; k++) begin
            s_tvalid = 1'b1; s_tdata = 16'(16'h0100 + k);
            tick_clk();
            if (k < 16) chk("full_fill", 32'(fill_level), 32'(k + 1));
            chk("full_ready", 32'(s_tready), 32'(k < 15));
        end
        chk("full_fill16", 32'(fill_level), 32'd16);
        enable = 1'b1;
        tick_clk();
        tick_clk();
        chk("full_ready_run", 32'(s_tready), 32'd0);
        tick_clk();
        chk("full_pop_data", 32'(m_tdata), 32'h0100);
        chk("full_pop_fill", 32'(fill_level), 32'd15);
        chk("full_ready_after_pop", 32'(s_tready), 32'd1);
        tick_clk();
        s_tvalid = 1'b0;
        chk("full_17th_fill", 32'(fill_level), 32'd16);
        chk("full_17th_ready", 32'(s_tready), 32'd0);
        enable = 1'b0;
        tick_clk();
        chk("full_idle_running", 32'(running), 32'd0);
        chk("full_idle_fill", 32'(fill_level), 32'd16);

        // Clear before late-consumer case
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        chk("clr_fill", 32'(fill_level), 32'd0);
        chk("clr_underrun", 32'(underrun_cnt), 32'd0);
        chk("clr_ready", 32'(s_tready), 32'd1);

        // Late consumer
        for (int k = 0; k < 4; k++) begin
            s_tvalid = 1'b1; s_tdata = samp[k];
            tick_clk();
        end
        s_tvalid = 1'b0;
        enable = 1'b1;
        tick_clk();
        tick_clk();
        m_tready = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick_clk();
            chk("late_valid", 32'(m_tvalid), 32'd1);
            chk("late_data", 32'(m_tdata), 32'h1111);
        end
        chk("late_cnt", 32'(late_cnt), 32'd2);
        chk("late_fill", 32'(fill_level), 32'd3);
        chk("late_underrun", 32'(underrun_cnt), 32'd0);
        m_tready = 1'b1;
        tick_clk();
        chk("late_accept", 32'(m_tvalid), 32'd0);
        for (int j = 21; j < 25; j++) tick_clk();
        chk("late_next_valid", 32'(m_tvalid), 32'd1);
        chk("late_next_data", 32'(m_tdata), 32'h2222);
        chk("late_next_fill", 32'(fill_level), 32'd2);

        // Disable while pending, then reset
        m_tready = 1'b0;
        enable = 1'b0;
        tick_clk();
        chk("dis_running", 32'(running), 32'd0);
        for (int j = 0; j < 20; j++) begin
            tick_clk();
            chk("dis_hold_valid", 32'(m_tvalid), 32'd1);
            chk("dis_hold_data", 32'(m_tdata), 32'h2222);
        end
        chk("dis_fill", 32'(fill_level), 32'd2);
        chk("dis_late", 32'(late_cnt), 32'd2);
        m_tready = 1'b1;
        tick_clk();
        chk("dis_accept", 32'(m_tvalid), 32'd0);
        tick_clk();
        chk("dis_no_pop", 32'(fill_level), 32'd2);
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        chk("end_fill", 32'(fill_level), 32'd0);
        chk("end_late", 32'(late_cnt), 32'd0);
        chk("end_underrun", 32'(underrun_cnt), 32'd0);
        chk("end_m_tdata", 32'(m_tdata), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_dac_pacer.md
# axis_dac_pacer

Upstream sample-pacing stage for the MAX5316 DAC path. It accepts 16-bit DAC codes on an AXI-Stream slave from the PS/DMA side and buffers them in a small FIFO. It releases them on an AXI-Stream master at a fixed, programmable sample rate to the DAC serializer. Underruns and late consumer acceptance are counted, and the last sample is held so the analog output never glitches.

## Interface
Parameters:
- DATA_W, 16, sample width (DAC code width).
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries.
- RATE_DIV, 1000, clk cycles per output sample; legal range 2..65535.
- PRIME_LEVEL, 2, FIFO entries required before pacing starts; legal range 1..2^DEPTH_LOG2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  run request from the register block.
- s_tdata  in  DATA_W  input sample.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready; equals !full.
- m_tdata  out  DATA_W  paced sample to the DAC serializer.
- m_tvalid  out  1  paced sample valid.
- m_tready  in  1  serializer ready.
- fill_level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- underrun_cnt  out  16  ticks that found the FIFO empty; saturates at 0xFFFF.
- late_cnt  out  16  ticks that found m_tvalid still pending; saturates at 0xFFFF.
- running  out  1  high while in RUN.

## Operation
- FIFO: circular buffer with registered read/write pointers that wrap at 2^DEPTH_LOG2. Push occurs on s_tvalid&&s_tready. Pop occurs only on a pacing tick (see below).
- Push and pop in the same cycle leave fill_level unchanged. When full, s_tready is low even if a pop occurs that cycle; there is no fall-through.
- FIFO contents are retained across enable toggles and cleared only by rst.
- FSM states and transitions:
  - IDLE: the pacer counter is stopped. Go to PRIME when enable=1.
  - PRIME: go to RUN when fill_level >= PRIME_LEVEL. Go to IDLE when enable=0.
  - RUN: running=1. Go to IDLE when enable=0; underrun does not leave RUN.
- Pacer counter: 16-bit down-counter, loaded with 0 on entry to RUN. A tick occurs each RUN cycle in which the counter is 0; the counter then reloads with RATE_DIV-1, otherwise it decrements. The first tick occurs in the first RUN cycle, and the tick period is exactly RATE_DIV cycles.
- On a tick, exactly one case applies:
  - m_tvalid=1 (pending, unaccepted): no pop, m_tdata held, late_cnt++.
  - else if FIFO non-empty: pop the head into m_tdata and set m_tvalid=1.
  - else (empty): m_tdata keeps the last value, m_tvalid=1 (the repeat is re-sent), underrun_cnt++.
- m_tvalid clears on the cycle after m_tvalid&&m_tready. Once asserted, m_tvalid and m_tdata stay stable until accepted, including after enable falls.
- Counters saturate and never wrap. They are cleared only by rst.

## Timing
- Reset values: s_tready=1, m_tvalid=0, m_tdata=0, fill_level=0, underrun_cnt=0, late_cnt=0, running=0. The FSM resets to IDLE, the pointers to 0, and the pacer counter to 0.
- rst mid-operation discards the FIFO, any pending m_tvalid and the counters in the same edge.
- A sample pushed in cycle T is visible in fill_level at T+1 and is poppable from T+1.
- Enable rise at T with fill_level>=PRIME_LEVEL: PRIME at T+1, RUN at T+2, first tick at T+2, m_tvalid=1 at T+3.
- Tick at T: m_tvalid/m_tdata update at T+1, fill_level decrements at T+1, and counter increments are visible at T+1.
- Enable fall at T: IDLE at T+1 and running=0 at T+1. No tick occurs at T+1 or later.
- All outputs are registered; there is no combinational path from s_* to m_*.

## Test plan
- Reset: assert rst 3 cycles with random inputs -> all outputs at the reset values above, with s_tready=1.
- Paced stream: RATE_DIV=8, PRIME_LEVEL=2, m_tready=1. Push 0x1111, 0x2222, 0x3333, 0x4444, then enable -> m_tvalid pulses 1 cycle wide, exactly 8 cycles apart, carrying the data in order. fill_level steps 4→0.
- Underrun: continue the previous case with no pushes for 2 more ticks -> m_tdata=0x4444 on both ticks, underrun_cnt=2, state stays RUN.
- Full: DEPTH_LOG2=4, enable=0, push 17 samples back-to-back -> 16 accepted, s_tready=0 from the cycle after the 16th push, fill_level=16. The 17th sample is accepted after a pop frees an entry.
- Late consumer: RATE_DIV=8, 4 samples queued, m_tready held low 20 cycles after the first tick -> late_cnt=2, m_tdata constant, fill_level=3. When m_tready rises, the next tick pops 0x2222.
- Disable/reset mid-run: drop enable while m_tvalid is pending -> m_tvalid held until accepted, running=0, no further pops. Then pulse rst -> fill_level=0 and both counters 0.
